// File: rtl/sha_sched_pkg.sv
// ============================================================================
// Module : sha_sched_pkg
// Brief  : Shared types, constants and the rotated first-one search used by
//          the SHA-256 request scheduler.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sha_sched_pkg;

  localparam int DIGEST_W  = 256;
  localparam int MAX_REQ   = 16;
  localparam int MAX_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } sched_state_e;

  // Returns {found, index}. The offsets are scanned farthest-first so the
  // last hit written is the one nearest to ptr.
  function automatic logic [MAX_IDX_W:0] rr_first_one(
    input logic [MAX_REQ-1:0]   req,
    input logic [MAX_IDX_W-1:0] ptr,
    input int unsigned          n
  );
    logic [MAX_IDX_W:0] res;
    int unsigned        idx;
    res = '0;
    for (int unsigned k = MAX_REQ; k > 0; k--) begin
      if (k <= n) begin
        idx = (32'(ptr) + k - 1) % n;
        if (req[idx[MAX_IDX_W-1:0]]) begin
          res = {1'b1, idx[MAX_IDX_W-1:0]};
        end
      end
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha_rr_arb.sv
// ============================================================================
// Module : sha_rr_arb
// Brief  : Combinational round-robin grant from req_valid and rr_ptr.
//          Define SHA_PRIORITY_EN to make requester 0 strict high priority.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sha_rr_arb
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic [NUM_REQ-1:0] gnt_onehot
);

  logic [MAX_REQ-1:0]   req_pad;
  logic [MAX_IDX_W-1:0] ptr_pad;
  logic [MAX_IDX_W:0]   rr_res;

  always_comb begin
    req_pad = MAX_REQ'(req_valid);
`ifdef SHA_PRIORITY_EN
    // Requester 0 is handled by the override; the rest rotate among themselves.
    req_pad[0] = 1'b0;
`endif
    ptr_pad    = MAX_IDX_W'(rr_ptr);
    rr_res     = rr_first_one(req_pad, ptr_pad, NUM_REQ);
    gnt_valid  = rr_res[MAX_IDX_W];
    gnt_idx    = IDX_W'(rr_res[MAX_IDX_W-1:0]);
`ifdef SHA_PRIORITY_EN
    if (req_valid[0]) begin
      gnt_valid = 1'b1;
      gnt_idx   = '0;
    end
`endif
    gnt_onehot = '0;
    if (gnt_valid) begin
      gnt_onehot[gnt_idx] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sha256_req_sched.sv
// ============================================================================
// Module : sha256_req_sched
// Brief  : Round-robin scheduler sharing one fixed-latency SHA-256 core
//          between NUM_REQ requesters. Optional macro: SHA_PRIORITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sha256_req_sched
  import sha_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MSG_SIZE     = 96,
  parameter int CORE_LATENCY = 80,
  parameter int IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*MSG_SIZE-1:0] req_msg,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [MSG_SIZE-1:0]         core_message,
  output logic                        core_start,
  input  logic [DIGEST_W-1:0]         core_hashed,
  output logic                        rsp_valid,
  output logic [IDX_W-1:0]            rsp_id,
  output logic [DIGEST_W-1:0]         rsp_hash,
  input  logic                        rsp_ready,
  output logic                        busy
);

  localparam int             CNT_W    = $clog2(CORE_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LATENCY - 1);

  sched_state_e         state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     job_id_q, job_id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MSG_SIZE-1:0]  msg_q, msg_d;
  logic                 start_q, start_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [IDX_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DIGEST_W-1:0]  rsp_hash_q, rsp_hash_d;

  logic                 gnt_valid;
  logic [IDX_W-1:0]     gnt_idx;
  logic [NUM_REQ-1:0]   gnt_onehot;
  logic                 accept;

  sha_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_valid  (req_valid),
    .rr_ptr     (rr_ptr_q),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot)
  );

  // Grant is only offered in IDLE and never while reset is held.
  assign accept    = (state_q == IDLE) && gnt_valid && reset;
  assign req_ready = accept ? gnt_onehot : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = START;
      START:   state_d = WAIT;
      WAIT:    if (cnt_q == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    job_id_d    = job_id_q;
    cnt_d       = cnt_q;
    msg_d       = msg_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_hash_d  = rsp_hash_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          msg_d    = req_msg[gnt_idx*MSG_SIZE +: MSG_SIZE];
          job_id_d = gnt_idx;
          start_d  = 1'b1;
        end
      end
      START: cnt_d = CNT_LOAD;
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_hash_d  = core_hashed;
          rsp_id_d    = job_id_q;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
`ifdef SHA_PRIORITY_EN
          if (job_id_q != '0)
`endif
            rr_ptr_d = (job_id_q == IDX_W'(NUM_REQ - 1)) ? '0 : job_id_q + IDX_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr_q    <= '0;
      job_id_q    <= '0;
      cnt_q       <= '0;
      msg_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_hash_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      job_id_q    <= job_id_d;
      cnt_q       <= cnt_d;
      msg_q       <= msg_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_hash_q  <= rsp_hash_d;
    end
  end

  assign core_message = msg_q;
  assign core_start   = start_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_hash     = rsp_hash_q;
  assign busy         = (state_q != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sha256_req_sched.sv
// ============================================================================
// Module : tb_sha256_req_sched
// Brief  : Directed bench for sha256_req_sched with a fixed-latency core model
//          whose digest is {160'h0, message}, valid only on the capture cycle.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sha256_req_sched;

  localparam int NUM_REQ  = 4;
  localparam int MSG_SIZE = 96;
  localparam int LAT      = 40;
  localparam int IDX_W    = 2;

  logic                        clk = 1'b0;
  logic                        reset = 1'b0;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*MSG_SIZE-1:0] req_msg = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic [MSG_SIZE-1:0]         core_message;
  logic                        core_start;
  logic [255:0]                core_hashed;
  logic                        rsp_valid;
  logic [IDX_W-1:0]            rsp_id;
  logic [255:0]                rsp_hash;
  logic                        rsp_ready = 1'b1;
  logic                        busy;

  int n_vec = 0;
  int n_err = 0;
  logic [MSG_SIZE-1:0] msgs [NUM_REQ];

  sha256_req_sched #(
    .NUM_REQ      (NUM_REQ),
    .MSG_SIZE     (MSG_SIZE),
    .CORE_LATENCY (LAT),
    .IDX_W        (IDX_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_msg      (req_msg),
    .req_ready    (req_ready),
    .core_message (core_message),
    .core_start   (core_start),
    .core_hashed  (core_hashed),
    .rsp_valid    (rsp_valid),
    .rsp_id       (rsp_id),
    .rsp_hash     (rsp_hash),
    .rsp_ready    (rsp_ready),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Core model: digest is only correct exactly LAT cycles after core_start.
  logic [15:0] mcnt = '0;
  always @(posedge clk) begin
    if (core_start) mcnt <= 16'd1;
    else if (mcnt != 16'd0 && mcnt != 16'hffff) mcnt <= mcnt + 16'd1;
  end
  assign core_hashed = (mcnt == 16'(LAT)) ? {160'h0, core_message} : {8{32'hdeadbeef}};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = '1;
    for (int i = 0; i < NUM_REQ; i++) req_msg[i*MSG_SIZE +: MSG_SIZE] = msgs[i];
    repeat (3) step();
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rst_req_ready: got %b exp 0000", req_ready); end
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start: got %b exp 0", core_start); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
    n_vec++; if (core_message !== '0) begin n_err++; $display("FAIL rst_core_message: got %h exp 0", core_message); end
    n_vec++; if (rsp_hash !== '0 || rsp_id !== '0) begin n_err++; $display("FAIL rst_rsp: got id %0d hash %h exp 0", rsp_id, rsp_hash); end
  endtask

  task automatic test_fairness();
    int n;
    int e;
    logic [NUM_REQ-1:0] exp_rdy;
    reset = 1'b1;
    #1;
    for (int j = 0; j < 5; j++) begin
      e = j % NUM_REQ;
      exp_rdy = NUM_REQ'(1 << e);
      n = 0;
      while (req_ready === '0 && n < 50) begin step(); n++; end
      n_vec++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_grant%0d: got %b exp %b", j, req_ready, exp_rdy); end
      step();
      n_vec++; if (core_start !== 1'b1 || core_message !== msgs[e]) begin n_err++; $display("FAIL fair_start%0d: got start %b msg %h exp 1 %h", j, core_start, core_message, msgs[e]); end
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
      n_vec++; if (n != LAT + 1) begin n_err++; $display("FAIL fair_latency%0d: got %0d exp %0d", j, n, LAT + 1); end
      n_vec++; if (rsp_id !== IDX_W'(e)) begin n_err++; $display("FAIL fair_id%0d: got %0d exp %0d", j, rsp_id, e); end
      n_vec++; if (rsp_hash !== {160'h0, msgs[e]}) begin n_err++; $display("FAIL fair_hash%0d: got %h exp %h", j, rsp_hash, {160'h0, msgs[e]}); end
      if (j == 4) req_valid = '0;
      step();
      n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL fair_rsp_drop%0d: got %b exp 0", j, rsp_valid); end
    end
  endtask

  task automatic test_single_job();
    int n;
    req_valid = 4'b0100;
    #1;
    n_vec++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_grant: got %b exp 0100", req_ready); end
    step();
    req_valid = '0;
    #1;
    n_vec++; if (core_start !== 1'b1 || core_message !== msgs[2]) begin n_err++; $display("FAIL single_start: got %b %h exp 1 %h", core_start, core_message, msgs[2]); end
    n_vec++; if (req_ready !== 4'b0000 || busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got rdy %b busy %b exp 0000 1", req_ready, busy); end
    step();
    n_vec++; if (core_start !== 1'b0) begin n_err++; $display("FAIL single_start_pulse: got %b exp 0", core_start); end
    n = 1;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    n_vec++; if (n != LAT + 1) begin n_err++; $display("FAIL single_latency: got %0d exp %0d", n, LAT + 1); end
    n_vec++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d exp 2", rsp_id); end
    n_vec++; if (rsp_hash !== {160'h0, 96'h47756e647920526f636b7321}) begin n_err++; $display("FAIL single_hash: got %h", rsp_hash); end
    step();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got valid %b busy %b exp 0 0", rsp_valid, busy); end
  endtask

  task automatic test_backpressure();
    int n;
    int bad_valid, bad_id, bad_hash, bad_rdy;
    bad_valid = 0; bad_id = 0; bad_hash = 0; bad_rdy = 0;
    rsp_ready = 1'b0;
    req_valid = 4'b1000;
    #1;
    n_vec++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_grant_wrap: got %b exp 1000", req_ready); end
    step();
    req_valid = 4'b0010;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    n_vec++; if (n != LAT + 1) begin n_err++; $display("FAIL bp_latency: got %0d exp %0d", n, LAT + 1); end
    for (int c = 0; c < 20; c++) begin
      step();
      if (rsp_valid !== 1'b1) bad_valid++;
      if (rsp_id !== 2'd3) bad_id++;
      if (rsp_hash !== {160'h0, msgs[3]}) bad_hash++;
      if (req_ready !== 4'b0000 || busy !== 1'b1) bad_rdy++;
    end
    n_vec++; if (bad_valid != 0) begin n_err++; $display("FAIL bp_hold_valid: got %0d bad cycles exp 0", bad_valid); end
    n_vec++; if (bad_id != 0) begin n_err++; $display("FAIL bp_hold_id: got %0d bad cycles exp 0", bad_id); end
    n_vec++; if (bad_hash != 0) begin n_err++; $display("FAIL bp_hold_hash: got %0d bad cycles exp 0", bad_hash); end
    n_vec++; if (bad_rdy != 0) begin n_err++; $display("FAIL bp_hold_busy: got %0d bad cycles exp 0", bad_rdy); end
    rsp_ready = 1'b1;
    #1;
    n_vec++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_handshake_cycle: got %b exp 1", rsp_valid); end
    step();
    n_vec++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL bp_idle: got valid %b busy %b exp 0 0", rsp_valid, busy); end
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_next_grant: got %b exp 0010", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_reset_mid_wait();
    int n;
    int bad;
    bad = 0;
    req_valid = 4'b0001;
    #1;
    n_vec++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rmw_grant: got %b exp 0001", req_ready); end
    step();
    req_valid = '0;
    repeat (30) step();
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmw_waiting: got busy %b exp 1", busy); end
    #2;
    reset     = 1'b0;
    req_valid = 4'b0010;
    #1;
    n_vec++; if (busy !== 1'b0 || core_message !== '0 || core_start !== 1'b0) begin n_err++; $display("FAIL rmw_async_clear: got busy %b msg %h start %b", busy, core_message, core_start); end
    n_vec++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL rmw_ready_in_reset: got %b exp 0000", req_ready); end
    for (int c = 0; c < LAT + 5; c++) begin
      step();
      if (rsp_valid !== 1'b0) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL rmw_no_rsp: got %0d valid cycles exp 0", bad); end
    reset = 1'b1;
    #1;
    n_vec++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL rmw_regrant: got %b exp 0010", req_ready); end
    step();
    req_valid = '0;
    n = 0;
    while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
    n_vec++; if (n != LAT + 1 || rsp_id !== 2'd1) begin n_err++; $display("FAIL rmw_job: got lat %0d id %0d exp %0d 1", n, rsp_id, LAT + 1); end
    step();
  endtask

`ifdef SHA_PRIORITY_EN
  task automatic test_priority();
    int n;
    req_valid = 4'b1001;
    for (int j = 0; j < 4; j++) begin
      n = 0;
      while (req_ready === '0 && n < 50) begin step(); n++; end
      n_vec++; if (req_ready !== ((j < 3) ? 4'b0001 : 4'b1000)) begin n_err++; $display("FAIL prio_grant%0d: got %b", j, req_ready); end
      step();
      n = 0;
      while (rsp_valid !== 1'b1 && n < 200) begin step(); n++; end
      n_vec++; if (rsp_id !== ((j < 3) ? 2'd0 : 2'd3)) begin n_err++; $display("FAIL prio_id%0d: got %0d", j, rsp_id); end
      if (j == 2) req_valid = 4'b1000;
      if (j == 3) req_valid = '0;
      step();
    end
  endtask
`endif

  initial begin
    msgs[0] = 96'h00112233_44556677_8899aabb;
    msgs[1] = 96'h0123456789abcdef01234567;
    msgs[2] = 96'h47756e647920526f636b7321;
    msgs[3] = 96'hfedcba98_76543210_a5a5a5a5;
    test_reset();
    test_fairness();
    test_single_job();
    test_backpressure();
    test_reset_mid_wait();
`ifdef SHA_PRIORITY_EN
    test_priority();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sha256_req_sched.md
Name: sha256_req_sched

Overview:
- Round-robin scheduler sharing one SHA-256 core (`top` instance, MSG_SIZE message in, 256-bit `hashed` out, single-cycle `start`) between NUM_REQ requesters.
- Accepts one message per job, pulses the core start, and waits a fixed CORE_LATENCY cycles; the core has no done flag.
- Captures the digest and returns it tagged with the requester index.
- Sits between client blocks and the hash core in the SHA-256 project top level.

Parameters:
- NUM_REQ, 4: number of requesters (2..16).
- MSG_SIZE, 96: message width, in bits; must match the core.
- CORE_LATENCY, 80: clock cycles from the core_start cycle to a valid core_hashed (≥2).
- IDX_W, $clog2(NUM_REQ): requester index width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset.
- req_valid  in  NUM_REQ  per-requester job request.
- req_msg  in  NUM_REQ*MSG_SIZE  packed messages; requester i occupies bits [i*MSG_SIZE +: MSG_SIZE].
- req_ready  out  NUM_REQ  one-hot accept strobe.
- core_message  out  MSG_SIZE  message driven to the core.
- core_start  out  1  one-cycle start pulse to the core.
- core_hashed  in  256  digest from the core.
- rsp_valid  out  1  digest available.
- rsp_id  out  IDX_W  index of the requester that owns rsp_hash.
- rsp_hash  out  256  captured digest.
- rsp_ready  in  1  consumer accepts the response.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, cnt=0; all registered outputs cleared (core_message, core_start, rsp_valid, rsp_id, rsp_hash). req_ready=0 while reset is asserted.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - req_ready = grant one-hot (combinational; zero when no request).
  - On accept (req_valid[g] & req_ready[g]): latch req_msg slice g into core_message, latch g as job id, go to START.
- START: core_start=1 for exactly this one cycle. cnt loads CORE_LATENCY-1. Go to WAIT.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==0: register core_hashed into rsp_hash, rsp_id=job id, rsp_valid=1, go to RESP.
  - Digest capture occurs CORE_LATENCY cycles after the core_start cycle.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_hash stable until rsp_ready=1.
  - On the handshake cycle: rsp_valid→0, rr_ptr=(job id+1) mod NUM_REQ, go to IDLE.
- Latency: accept at cycle T, core_start at T+1, rsp_valid at T+1+CORE_LATENCY+1 (minimum, with rsp_ready held high).
- core_message holds the latched message from accept until the next accept, so the core sees a stable input throughout hashing.
- Requester rules:
  - Must hold req_valid and req_msg stable until accepted.
  - May deassert req_valid before grant without any effect.
  - req_valid is ignored in every state except IDLE; req_ready=0 there.
- Simultaneous requests: exactly one grant per job. Pointer rotation prevents starvation; worst-case wait is NUM_REQ-1 jobs.
- rr_ptr wraps from NUM_REQ-1 to 0.
- Reset mid-job (any state): immediate return to IDLE. No response is produced and the job is lost; the requester must re-request.
- rsp_ready asserted outside RESP is ignored.

Optional Feature:
- Macro: SHA_PRIORITY_EN.
- When defined: requester 0 is strict high priority. If req_valid[0]=1 in IDLE it is granted regardless of rr_ptr, and rr_ptr is not updated after a requester-0 job. Requesters 1..NUM_REQ-1 keep round-robin among themselves.
- When undefined: pure round-robin across all NUM_REQ requesters, as described in Behaviour.

Decomposition:
- Package sha_sched_pkg:
  - state enum typedef (IDLE, START, WAIT, RESP);
  - DIGEST_W=256 constant;
  - a helper function that computes the rotated first-one index.
- Sub-module sha_rr_arb: combinational grant from (req_valid, rr_ptr), with the SHA_PRIORITY_EN override. Pointer storage stays in sha256_req_sched.
- The core stays external; no core instance inside this block.

Test Plan:
- Single job:
  - Stimulus: requester 2 sends 96'h47756e647920526f636b7321, with the real `top` core attached.
  - Required: req_ready[2] for one cycle; core_start one cycle later; rsp_valid after CORE_LATENCY+1 cycles; rsp_id=2; rsp_hash=256'h6afba0bb92737254ed97dd21d5ac868b2226417b8241e020a0996ed2c1ac6b27.
- Fairness:
  - Stimulus: all 4 requesters continuously valid from reset (SHA_PRIORITY_EN undefined), using a behavioral core model whose hash = {160'h0, msg}.
  - Required: grant order 0,1,2,3,0; each rsp_id matches its message.
- Backpressure:
  - Stimulus: rsp_ready=0 for 20 cycles after rsp_valid.
  - Required: rsp_valid, rsp_id and rsp_hash stay constant; req_ready stays 0; busy=1. Accept completes on the cycle rsp_ready=1, and IDLE follows the next cycle.
- Reset mid-WAIT:
  - Stimulus: assert reset 30 cycles after core_start.
  - Required: outputs clear asynchronously; no rsp_valid. After release, a new request on requester 1 is granted first (rr_ptr=0; req 0 idle).
- Priority build:
  - Stimulus: SHA_PRIORITY_EN defined, requesters 0 and 3 always valid.
  - Required: every job is granted to 0; requester 3 is granted only when req_valid[0]=0.
